// File: rtl/sdf_stage_ctrl_32.sv
// ---------------------------------------------------------------------------
// sdf_stage_ctrl_32
//
// Sequencer for one radix-2 single-path delay-feedback stage of a 32-point
// FFT: 16-sample delay line, butterfly and twiddle multiply. The controller
// walks FILL -> BFLY -> (TWID -> BFLY)* -> DRAIN for each stream of frames
// and tells the datapath which phase it is in and when to shift.
//
// Ports:
//   clk         single rising-edge clock
//   rst_n       synchronous active-low reset
//   clr         synchronous soft clear, identical effect to reset
//   in_valid    input sample presented this cycle
//   in_last     with in_valid, final sample of the final frame of a stream
//   in_ready    controller accepts a sample this cycle (low only in DRAIN)
//   mode        datapath phase: 0 IDLE, 1 FILL, 2 BFLY, 3 TWID, 4 DRAIN
//   tw_addr     twiddle index k of W32^k (step in TWID/DRAIN, else 0)
//   dl_shift    delay-line shift enable
//   out_valid   stage output sample valid this cycle
//   frame_done  one-cycle pulse on the final output sample of a frame
//   frames      completed-frame count, wraps at 2^FRAME_W
//   err         sticky protocol error (misplaced in_last)
// ---------------------------------------------------------------------------
module sdf_stage_ctrl_32 #(
    parameter int FRAME_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [2:0]         mode,
    output logic [3:0]         tw_addr,
    output logic               dl_shift,
    output logic               out_valid,
    output logic               frame_done,
    output logic [FRAME_W-1:0] frames,
    output logic               err
);

    // Encoding matches the mode port so mode is a direct copy of the phase.
    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_BFLY  = 3'd2,
        PH_TWID  = 3'd3,
        PH_DRAIN = 3'd4
    } phase_t;

    phase_t             phase;
    logic [3:0]         step;
    logic [FRAME_W-1:0] frame_cnt;
    logic               err_q;

    logic kill;
    logic accept;
    logic advance;
    logic last_step;

    // Handshake and datapath strobes. A reset or clear in the same cycle
    // suppresses the sample entirely, so the datapath must not shift or
    // emit anything either; everything else is decoded from the registered
    // phase and step only.
    always_comb begin
        kill       = ~rst_n | clr;
        in_ready   = (phase != PH_DRAIN);
        accept     = in_valid & in_ready & ~kill;
        advance    = (phase == PH_DRAIN) ? ~kill : accept;
        last_step  = (step == 4'd15);
        mode       = phase;
        tw_addr    = ((phase == PH_TWID) || (phase == PH_DRAIN)) ? step : 4'd0;
        dl_shift   = advance;
        out_valid  = advance & ((phase == PH_BFLY) || (phase == PH_TWID) ||
                                (phase == PH_DRAIN));
        frame_done = advance & last_step &
                     ((phase == PH_TWID) || (phase == PH_DRAIN));
        frames     = frame_cnt;
        err        = err_q;
    end

    // Phase/step sequencing, frame counter and sticky error. The step
    // counter is 4 bits, so step + 1 wraps 15 -> 0 exactly on the phase
    // transitions. The sample accepted in IDLE is step 0 of FILL, hence
    // FILL is entered at step 1. in_last only matters at BFLY step 15;
    // anywhere else it is flagged and otherwise ignored.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            phase     <= PH_IDLE;
            step      <= 4'd0;
            frame_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept && in_last && !((phase == PH_BFLY) && last_step))
                err_q <= 1'b1;
            if (frame_done)
                frame_cnt <= frame_cnt + 1'b1;
            if (advance) begin
                case (phase)
                    PH_IDLE: begin
                        phase <= PH_FILL;
                        step  <= 4'd1;
                    end
                    PH_FILL: begin
                        if (last_step)
                            phase <= PH_BFLY;
                        step <= step + 4'd1;
                    end
                    PH_BFLY: begin
                        if (last_step)
                            phase <= in_last ? PH_DRAIN : PH_TWID;
                        step <= step + 4'd1;
                    end
                    PH_TWID: begin
                        if (last_step)
                            phase <= PH_BFLY;
                        step <= step + 4'd1;
                    end
                    PH_DRAIN: begin
                        if (last_step)
                            phase <= PH_IDLE;
                        step <= step + 4'd1;
                    end
                    default: begin
                        phase <= PH_IDLE;
                        step  <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdf_stage_ctrl_32.sv
// ---------------------------------------------------------------------------
// tb_sdf_stage_ctrl_32
//
// Self-checking bench for sdf_stage_ctrl_32. The reference model tracks a
// stream as "number of samples accepted so far" plus a drain countdown, and
// derives the expected phase/step from that count (16-sample blocks: block
// 0 is IDLE+FILL, odd blocks are BFLY, later even blocks are TWID). Every
// output is compared every cycle, plus a few directed end-of-test checks.
// ---------------------------------------------------------------------------
module tb_sdf_stage_ctrl_32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [2:0] mode;
    logic [3:0] tw_addr;
    logic       dl_shift;
    logic       out_valid;
    logic       frame_done;
    logic [7:0] frames;
    logic       err;

    int checks = 0;
    int passes = 0;
    int fd_seen = 0;
    int twid_seen = 0;

    // Reference model state
    int m_n = 0;
    int m_d = 0;
    bit m_drain = 0;
    int m_frames = 0;
    bit m_err = 0;
    bit m_known = 0;

    always #5 clk = ~clk;

    sdf_stage_ctrl_32 #(.FRAME_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mode       (mode),
        .tw_addr    (tw_addr),
        .dl_shift   (dl_shift),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .frames     (frames),
        .err        (err)
    );

    // One comparison: counts it and reports any difference.
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected outputs for the current cycle from the model and inputs.
    task automatic checkOutput();
        int  e_mode;
        int  e_tw;
        bit  kill;
        bit  e_adv;
        bit  e_ov;
        bit  e_fd;
        kill = (rst_n == 1'b0) || (clr == 1'b1);
        if (m_drain)              e_mode = 4;
        else if (m_n == 0)        e_mode = 0;
        else if (m_n < 16)        e_mode = 1;
        else if ((m_n / 16) % 2)  e_mode = 2;
        else                      e_mode = 3;
        e_adv = !kill && (m_drain || in_valid);
        e_tw  = m_drain ? m_d : ((e_mode == 3) ? (m_n % 16) : 0);
        e_ov  = e_adv && (e_mode >= 2);
        e_fd  = e_adv && ((m_drain && m_d == 15) ||
                          (e_mode == 3 && (m_n % 16) == 15));
        check("mode",       32'(mode),       32'(e_mode));
        check("in_ready",   32'(in_ready),   32'(!m_drain));
        check("tw_addr",    32'(tw_addr),    32'(e_tw));
        check("dl_shift",   32'(dl_shift),   32'(e_adv));
        check("out_valid",  32'(out_valid),  32'(e_ov));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("frames",     32'(frames),     32'(m_frames));
        check("err",        32'(err),        32'(m_err));
        if (frame_done === 1'b1) fd_seen++;
        if (mode === 3'd3)       twid_seen++;
    endtask

    // Drive one cycle, check outputs mid-cycle, then advance the model.
    task automatic applyStimulus(input bit v, input bit l, input bit r,
                                 input bit c);
        bit bfly_end;
        bit twid_end;
        @(negedge clk);
        in_valid = v;
        in_last  = l;
        rst_n    = r;
        clr      = c;
        #1;
        if (m_known) checkOutput();
        @(posedge clk);
        bfly_end = (m_n % 16 == 15) && ((m_n / 16) % 2 == 1);
        twid_end = (m_n % 16 == 15) && (m_n >= 32) && ((m_n / 16) % 2 == 0);
        if (!r || c) begin
            m_n = 0; m_d = 0; m_drain = 0; m_frames = 0; m_err = 0;
            m_known = 1;
        end else if (m_drain) begin
            if (m_d == 15) begin
                m_drain = 0; m_d = 0; m_n = 0;
                m_frames = (m_frames + 1) % 256;
            end else begin
                m_d++;
            end
        end else if (v) begin
            if (l && !bfly_end) m_err = 1;
            if (l && bfly_end) begin
                m_drain = 1;
                m_d = 0;
            end else begin
                if (twid_end) m_frames = (m_frames + 1) % 256;
                m_n++;
            end
        end
    endtask

    // Send count samples with optional random idle gaps; in_last is raised
    // on sample last_at (stream end) and on sample err_at (misplaced).
    task automatic send_samples(input int count, input int last_at,
                                input int err_at, input int gappct);
        for (int i = 0; i < count; i++) begin
            if (gappct > 0 && $urandom_range(0, 99) < gappct)
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            applyStimulus(1'b1, (i == last_at) || (i == err_at), 1'b1, 1'b0);
        end
    endtask

    // Run through DRAIN with junk on the inputs, which must be ignored.
    task automatic wait_drain();
        int k = 0;
        while (m_drain && k < 40) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'b1, 1'b0);
            k++;
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int fd0;
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] single frame");
        send_samples(32, 31, -1, 0);
        wait_drain();
        check("single_frames", 32'(frames), 32'd1);

        $display("[TB] two back-to-back frames");
        fd0 = fd_seen;
        send_samples(64, 63, -1, 0);
        wait_drain();
        check("two_frame_pulses", 32'(fd_seen - fd0), 32'd2);
        check("two_frames_total", 32'(frames), 32'd3);

        $display("[TB] gapped input");
        twid_seen = 0;
        send_samples(64, 63, -1, 100);
        wait_drain();
        check("twid_cycles", 32'(twid_seen), 32'd32);

        $display("[TB] random gaps, three frames");
        send_samples(96, 95, -1, 30);
        wait_drain();

        $display("[TB] protocol error and clear");
        send_samples(32, 31, 5, 20);
        wait_drain();
        check("err_sticky", 32'(err), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        check("err_cleared", 32'(err), 32'd0);

        $display("[TB] in_last in IDLE");
        send_samples(32, 31, 0, 0);
        wait_drain();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);

        $display("[TB] clear with valid mid-fill");
        send_samples(10, -1, -1, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        send_samples(32, 31, -1, 10);
        wait_drain();

        $display("[TB] reset at TWID step 7");
        send_samples(39, -1, -1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        check("rst_mid_mode", 32'(mode), 32'd0);
        check("rst_mid_tw", 32'(tw_addr), 32'd0);
        send_samples(32, 31, -1, 0);
        wait_drain();
        check("rst_mid_frames", 32'(frames), 32'd1);

        $display("[TB] 256-frame wrap");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        fd0 = fd_seen;
        send_samples(8192, 8191, -1, 10);
        wait_drain();
        check("wrap_pulses", 32'(fd_seen - fd0), 32'd256);
        check("wrap_frames", 32'(frames), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
